// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver and the transmitter:
//   - FSM state encoding (IDLE/START/DATA/STOP), 2-bit legacy-compatible codes
//   - default bit period in clk cycles (217, e.g. 25 MHz / 115200 baud)
//   - helper to size the per-bit cycle counter
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 217;

    localparam int         UART_STATE_W = 2;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_DATA      = 2'd2;
    localparam logic [1:0] ST_STOP      = 2'd3;

    // Width of a counter that runs 0 .. cpb-1.
    function automatic int uart_cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (both flops load RESET_VAL)
//   d_i   - asynchronous input
//   q_o   - synchronized output (2 cycles of latency)
// Parameter RESET_VAL: value both flops take on reset (1 for an idle-high line).
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// -----------------------------------------------------------------------------
// uart_rx_8n1
// UART receiver, 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
// Ports:
//   clk     - single clock, all logic on the rising edge
//   rst     - synchronous active-high reset
//   rx      - asynchronous serial input
//   rxbyte  - last received byte, held until the next rxdone
//   rxdone  - one-cycle pulse, rxbyte valid in that cycle
//   rxbusy  - high whenever the receiver FSM is not IDLE
//   rxerror - one-cycle framing-error pulse (only with UART_RX_FRAME_ERR_EN)
// Parameter CLKS_PER_BIT: clk cycles per bit period, must be >= 4.
// Build option: define UART_RX_FRAME_ERR_EN to check the stop bit. A stop
// sample of 0 then raises rxerror instead of delivering the byte. Without the
// macro the rxerror port does not exist and every frame is delivered.
// -----------------------------------------------------------------------------
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxdone,
    output logic       rxbusy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       rxerror
`endif
);

    localparam int                CNT_W         = uart_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    // The start bit is checked half a bit after the edge; later samples are
    // then one full bit apart, which lands each of them mid-bit.
    localparam logic [CNT_W-1:0]  CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);

    // ---------------------------------------------------------------------
    // Input synchronization and falling-edge detection
    // ---------------------------------------------------------------------
    logic rx_s;
    logic rx_prev_q;
    logic rx_fall;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // rx_prev_q tracks rx_s in every state, so an edge that arrives right
    // after the stop sample is seen as soon as the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
        end
    end

    // Only a 1 -> 0 transition starts a frame; a line that merely stays low
    // (break, stuck line) never restarts the receiver.
    assign rx_fall = rx_prev_q & ~rx_s;

    // ---------------------------------------------------------------------
    // Receiver FSM
    // ---------------------------------------------------------------------
    logic [UART_STATE_W-1:0] state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [2:0]              bit_q,    bit_d;
    logic [7:0]              shift_q,  shift_d;
    logic [7:0]              rxbyte_q, rxbyte_d;
    logic                    done_q,   done_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic                    err_q,    err_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rxbyte_d = rxbyte_q;
        done_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        err_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // Line back high at mid-start: a glitch, drop it silently.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first: shift right, new bit enters at [7].
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                    if (rx_s) begin
                        rxbyte_d = shift_q;
                        done_d   = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                    end
`else
                    rxbyte_d = shift_q;
                    done_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            rxbyte_q <= 8'h00;
            done_q   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rxbyte_q <= rxbyte_d;
            done_q   <= done_d;
`ifdef UART_RX_FRAME_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign rxbyte = rxbyte_q;
    assign rxdone = done_q;
    assign rxbusy = (state_q != ST_IDLE);
`ifdef UART_RX_FRAME_ERR_EN
    assign rxerror = err_q;
`endif

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217: clk cycles per bit period, legal range >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rxbyte, output, 8 bits: last received byte, held stable until the next rxdone.
REQ-006 SHALL have port rxdone, output, 1 bit: one-cycle pulse, rxbyte valid in that cycle.
REQ-007 SHALL have port rxbusy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 SHALL have port rxerror, output, 1 bit, only when UART_RX_FRAME_ERR_EN is defined: one-cycle framing-error pulse.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer before any use; rx_s is the synchronized value.
REQ-010 SHALL implement states IDLE, START, DATA, STOP.
REQ-011 IDLE -> START on a falling edge of rx_s (prior 1, current 0) only; a level-low line in IDLE SHALL NOT start a frame.
REQ-012 START: count CLKS_PER_BIT/2 (integer division) cycles from the edge, then sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no pulse).
REQ-013 DATA: sample rx_s every CLKS_PER_BIT cycles; shift in LSB first; after the 8th sample -> STOP.
REQ-014 STOP: sample rx_s CLKS_PER_BIT cycles after the 8th data sample, then -> IDLE in the same cycle.
REQ-015 Stop sample 1: rxbyte <= shift register and rxdone = 1 in the next cycle (latency: 1 cycle after the stop mid-sample).
REQ-016 Bit counter SHALL be 3 bits wide; the cycle counter SHALL be $clog2(CLKS_PER_BIT) bits and SHALL wrap to 0 at CLKS_PER_BIT-1.
REQ-017 A back-to-back start edge arriving within half a bit after the stop sample SHALL be accepted (IDLE edge detection active immediately).
REQ-018 rxdone and rxerror SHALL never be high together and SHALL never last more than one cycle.

Reset
REQ-019 On rst=1 at a clock edge: state = IDLE; counters = 0; shift register = 0; rxbyte = 8'h00; rxdone = 0; rxerror = 0; rxbusy = 0; both synchronizer flops = 1.
REQ-020 Reset mid-frame SHALL abandon the frame without any rxdone or rxerror pulse.

Configuration
REQ-021 Macro UART_RX_FRAME_ERR_EN defined: a stop sample of 0 pulses rxerror for one cycle, leaves rxbyte unchanged, and gives no rxdone.
REQ-022 Macro UART_RX_FRAME_ERR_EN undefined: the rxerror port is absent, and the byte is delivered with rxdone regardless of the stop sample value.

Structure
REQ-023 Package uart_pkg SHALL hold the state encoding (shared with the transmitter) and the default CLKS_PER_BIT constant.
REQ-024 The synchronizer SHALL be the sub-module uart_sync2 (2 flops, reset value parameterizable, here 1).

Verification (bench CLKS_PER_BIT=16)
REQ-025 Send 8'hA5 with a valid stop bit -> exactly one rxdone pulse, rxbyte = 8'hA5, 1 cycle after the stop mid-sample.
REQ-026 Send 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap -> three rxdone pulses, in order, with the correct values.
REQ-027 Drive a 4-cycle low glitch on an idle line -> no rxdone, no rxerror, rxbusy returns to 0 within 10 cycles.
REQ-028 Send 8'h3C with stop bit = 0 -> with macro: rxerror pulse and rxbyte keeps its old value; without macro: rxdone with rxbyte = 8'h3C.
REQ-029 Assert rst during bit 4 of 8'h81, then send 8'h42 -> no pulse from the aborted frame; rxbyte = 8'h42 after the second frame.
REQ-030 Hold rx low for 20 bit periods, then release -> at most one frame decoded (8'h00, error or done per macro), and no new frame starts until a fresh falling edge.
